jmp: RTL and testbench

Conditional-jump unit for MIX command 39 (JMP, JSJ, JOV, JNOV, JL, JE, JG, JGE, JNE, JLE). It owns the comparison indicator (CI), which is loaded from the `greater`/`less` flags of the compare unit after every CMPx. On a start pulse it evaluates the F-field condition against CI or the overflow toggle, and returns jump/target to the sequencer. It also maintains rJ and requests an overflow clear when JOV or JNOV consumes the toggle.

---
 rtl/mix_pkg.sv | 24 ++
 rtl/jmp_cond.sv | 39 +++
 rtl/jmp.sv | 98 +++++++++
 tb/tb_jmp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared MIX definitions: F-field codes for command 39, comparison indicator
// encodings and the default address width.
package mix_pkg;

  localparam int ADDR_W_DEF = 12;

  localparam logic [5:0] F_JMP  = 6'd0;
  localparam logic [5:0] F_JSJ  = 6'd1;
  localparam logic [5:0] F_JOV  = 6'd2;
  localparam logic [5:0] F_JNOV = 6'd3;
  localparam logic [5:0] F_JL   = 6'd4;
  localparam logic [5:0] F_JE   = 6'd5;
  localparam logic [5:0] F_JG   = 6'd6;
  localparam logic [5:0] F_JGE  = 6'd7;
  localparam logic [5:0] F_JNE  = 6'd8;
  localparam logic [5:0] F_JLE  = 6'd9;

  localparam logic [1:0] CI_EQUAL   = 2'b00;
  localparam logic [1:0] CI_LESS    = 2'b01;
  localparam logic [1:0] CI_GREATER = 2'b10;

  typedef enum logic {S_IDLE, S_EXEC} jmp_state_t;

endpackage

// File: rtl/jmp_cond.sv
// Combinational condition decode for the jump unit: F field against CI and
// the overflow toggle.
module jmp_cond
  import mix_pkg::*;
(
  input  logic [5:0] field,
  input  logic [1:0] ci,
  input  logic       overflow,
  output logic       take,
  output logic       illegal,
  output logic       ovf_clr
);

  always_comb begin
    take    = 1'b0;
    illegal = 1'b0;
    ovf_clr = 1'b0;
    case (field)
      F_JMP, F_JSJ: take = 1'b1;
      // JOV/JNOV consume the toggle whether or not the jump is taken
      F_JOV: begin
        take    = overflow;
        ovf_clr = overflow;
      end
      F_JNOV: begin
        take    = ~overflow;
        ovf_clr = overflow;
      end
      F_JL:   take = (ci == CI_LESS);
      F_JE:   take = (ci == CI_EQUAL);
      F_JG:   take = (ci == CI_GREATER);
      F_JGE:  take = (ci != CI_LESS);
      F_JNE:  take = (ci != CI_EQUAL);
      F_JLE:  take = (ci != CI_GREATER);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/jmp.sv
// Conditional-jump unit for MIX command 39. Owns the comparison indicator and
// rJ; two-state sequencer returns jump/target one cycle after start.
module jmp
  import mix_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [5:0]        field,
  input  logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ci_load,
  input  logic              greater,
  input  logic              less,
  input  logic              overflow,
  output logic              stop,
  output logic              jump,
  output logic [ADDR_W-1:0] target,
  output logic              ovf_clear,
  output logic              illegal,
  output logic [1:0]        ci,
  output logic [ADDR_W-1:0] rj
);

  jmp_state_t        state;
  logic [5:0]        f_q;
  logic [ADDR_W-1:0] m_q;
  logic [ADDR_W-1:0] pc_q;
  logic              take;
  logic              ill;
  logic              ovf_clr;

  jmp_cond u_cond (
    .field    (f_q),
    .ci       (ci),
    .overflow (overflow),
    .take     (take),
    .illegal  (ill),
    .ovf_clr  (ovf_clr)
  );

  // CI runs independently of the FSM; the 11 pair is rejected
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ci <= CI_EQUAL;
    end else if (ci_load) begin
      case ({greater, less})
        2'b10:   ci <= CI_GREATER;
        2'b01:   ci <= CI_LESS;
        2'b00:   ci <= CI_EQUAL;
        default: ci <= ci;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      f_q       <= '0;
      m_q       <= '0;
      pc_q      <= '0;
      stop      <= 1'b0;
      jump      <= 1'b0;
      ovf_clear <= 1'b0;
      illegal   <= 1'b0;
      target    <= '0;
      rj        <= '0;
    end else begin
      stop      <= 1'b0;
      jump      <= 1'b0;
      ovf_clear <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            f_q   <= field;
            m_q   <= address;
            pc_q  <= pc;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          stop      <= 1'b1;
          jump      <= take;
          ovf_clear <= ovf_clr;
          illegal   <= ill;
          target    <= m_q;
          if (take && f_q != F_JSJ) rj <= pc_q;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jmp.sv
// Self-checking bench for jmp: directed vector table, hand-written corner
// sequences and randomized operations against a behavioural model.
module tb_jmp;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    field = '0;
  logic [AW-1:0] address = '0;
  logic [AW-1:0] pc = '0;
  logic          ci_load = 1'b0;
  logic          greater = 1'b0;
  logic          less = 1'b0;
  logic          overflow = 1'b0;
  logic          stop, jump, ovf_clear, illegal;
  logic [AW-1:0] target, rj;
  logic [1:0]    ci;

  jmp #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .field(field),
    .address(address), .pc(pc), .ci_load(ci_load), .greater(greater),
    .less(less), .overflow(overflow), .stop(stop), .jump(jump),
    .target(target), .ovf_clear(ovf_clear), .illegal(illegal),
    .ci(ci), .rj(rj)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: comparison outcome as a sign (-1 less, 0 equal, +1 greater)
  int            cmp_m = 0;
  int            rj_m = 0;
  int            tgt_m = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ci_code(input int c);
    if (c == 0) return 0;
    if (c < 0) return 1;
    return 2;
  endfunction

  function automatic bit model_take(input int f, input int c, input bit ovf);
    case (f)
      0, 1: return 1'b1;
      2: return ovf;
      3: return !ovf;
      4: return c < 0;
      5: return c == 0;
      6: return c > 0;
      7: return c >= 0;
      8: return c != 0;
      9: return c <= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_ci(input bit g, input bit l);
    if (g && !l) cmp_m = 1;
    else if (l && !g) cmp_m = -1;
    else if (!g && !l) cmp_m = 0;
  endfunction

  // Caller sits at a negedge; returns at the negedge where stop should be 1.
  task automatic run_op(input int f, input int m, input int p, input bit ovf,
                        input bit cild, input bit g, input bit l);
    bit tk;
    start = 1'b1; field = 6'(f); address = AW'(m); pc = AW'(p);
    overflow = ovf; ci_load = cild; greater = g; less = l;
    if (cild) model_ci(g, l);
    @(negedge clk);
    start = 1'b0; ci_load = 1'b0;
    tk = model_take(f, cmp_m, ovf);
    @(negedge clk);
    if (tk && f != 1) rj_m = p;
    tgt_m = m;
    chk("stop", int'(stop), 1);
    chk("jump", int'(jump), int'(tk));
    chk("target", int'(target), tgt_m);
    chk("ovf_clear", int'(ovf_clear), int'((f == 2 || f == 3) && ovf));
    chk("illegal", int'(illegal), int'(f > 9));
    chk("rj", int'(rj), rj_m);
    chk("ci", int'(ci), ci_code(cmp_m));
  endtask

  task automatic ci_pulse(input bit g, input bit l);
    ci_load = 1'b1; greater = g; less = l;
    model_ci(g, l);
    @(negedge clk);
    ci_load = 1'b0;
  endtask

  typedef struct {
    bit ci_ld; bit g; bit l;
    int f; int m; int p; bit ovf;
    bit e_jump; bit e_ovfc; bit e_ill; int e_rj;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{0,0,0, 0,100,51, 0, 1,0,0, 51};
    vt[1]  = '{1,1,0, 6,200,60, 0, 1,0,0, 60};
    vt[2]  = '{0,0,0, 9,210,61, 0, 0,0,0, 60};
    vt[3]  = '{0,0,0, 2,220,62, 1, 1,1,0, 62};
    vt[4]  = '{0,0,0, 3,230,63, 1, 0,1,0, 62};
    vt[5]  = '{0,0,0, 3,240,64, 0, 1,0,0, 64};
    vt[6]  = '{0,0,0, 0,5,77,   0, 1,0,0, 77};
    vt[7]  = '{0,0,0, 1,300,90, 0, 1,0,0, 77};
    vt[8]  = '{0,0,0, 12,310,91,0, 0,0,1, 77};
    vt[9]  = '{1,0,0, 5,320,92, 0, 1,0,0, 92};
    vt[10] = '{0,0,0, 8,330,93, 0, 0,0,0, 92};
    vt[11] = '{0,0,0, 7,340,94, 1, 1,0,0, 94};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_stop", int'(stop), 0);
    chk("rst_jump", int'(jump), 0);
    chk("rst_ovfc", int'(ovf_clear), 0);
    chk("rst_ill", int'(illegal), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_ci", int'(ci), 0);
    chk("rst_rj", int'(rj), 0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      if (vt[i].ci_ld) ci_pulse(vt[i].g, vt[i].l);
      run_op(vt[i].f, vt[i].m, vt[i].p, vt[i].ovf, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_jump", i), int'(jump), int'(vt[i].e_jump));
      chk($sformatf("vec%0d_ovfc", i), int'(ovf_clear), int'(vt[i].e_ovfc));
      chk($sformatf("vec%0d_ill", i), int'(illegal), int'(vt[i].e_ill));
      chk($sformatf("vec%0d_rj", i), int'(rj), vt[i].e_rj);
    end
    @(negedge clk);
    chk("idle_stop", int'(stop), 0);
    chk("idle_target_hold", int'(target), 340);

    // ci_load with start: CI is EQUAL, JL must see the new LESS
    run_op(4, 400, 101, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("same_cycle_jl", int'(jump), 1);

    // ci_load during EXEC: JL still sees LESS, GREATER lands afterwards
    start = 1'b1; field = 6'd4; address = 12'd410; pc = 12'd102;
    @(negedge clk);
    start = 1'b0; ci_load = 1'b1; greater = 1'b1; less = 1'b0;
    @(negedge clk);
    ci_load = 1'b0;
    cmp_m = 1; rj_m = 102;
    chk("exec_ci_jump", int'(jump), 1);
    chk("exec_ci_new", int'(ci), 2);

    // invalid pair leaves CI alone
    ci_pulse(1'b1, 1'b1);
    chk("ci_11_hold", int'(ci), 2);

    // start held through EXEC: only one stop
    begin
      int stops = 0;
      start = 1'b1; field = 6'd0; address = 12'd500; pc = 12'd103;
      @(negedge clk);
      address = 12'd777;
      @(negedge clk);
      start = 1'b0;
      rj_m = 103; tgt_m = 500;
      for (int c = 0; c < 4; c++) begin
        if (stop) stops++;
        if (c == 0) chk("dbl_target", int'(target), 500);
        @(negedge clk);
      end
      chk("dbl_stops", stops, 1);
    end

    // reset during EXEC: no stop, everything cleared
    start = 1'b1; field = 6'd0; address = 12'd600; pc = 12'd104;
    @(posedge clk);
    #1 reset_n = 1'b0; start = 1'b0;
    cmp_m = 0; rj_m = 0; tgt_m = 0;
    @(negedge clk);
    chk("rstx_stop", int'(stop), 0);
    chk("rstx_ci", int'(ci), 0);
    chk("rstx_rj", int'(rj), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstx_no_late_stop", int'(stop), 0);

    // randomized operations against the model
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        if ($urandom_range(0, 1)) ci_pulse(1'($urandom), 1'($urandom));
        else @(negedge clk);
      end
      run_op($urandom_range(0, 15), $urandom_range(0, 4095),
             $urandom_range(0, 4095), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    chk("final_stop", int'(stop), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
